// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM pipeline stage: FSM states, the latched control
// bundle, and helpers that classify an instruction from its control bits.
package mem_stage_pkg;

    localparam int RD_LAT_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic wbs;
        logic wme;
        logic mm;
        logic wm;
        logic ni;
    } mem_ctrl_t;

    function automatic logic is_load(input mem_ctrl_t c);
        return c.wbs & ~c.wme & ~c.mm;
    endfunction

    function automatic logic is_store(input mem_ctrl_t c);
        return c.wme & ~c.mm;
    endfunction

    function automatic logic is_io_store(input mem_ctrl_t c);
        return c.wme & c.mm;
    endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// Data RAM for the MEM stage: one write port and a registered read port whose
// result travels down an RD_LAT-deep pipeline. The first read stage forwards
// same-cycle write data so a load right behind a store sees the new value.
module mem_stage_ram
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    // Array write; contents are deliberately never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read stage 0 with write-through forwarding, then a plain delay line
    always_ff @(posedge clk) begin
        rd_pipe[0] <= (we && (waddr == raddr)) ? wdata : mem[raddr];
        for (int i = 1; i < RD_LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
        end
    end

    assign rdata = rd_pipe[RD_LAT-1];

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: holds one instruction, performs RAM stores, I/O write
// strobes and RD_LAT-cycle loads, stalls execute while a load is in flight,
// and presents retired results in the WB register.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_wbs,
    input  logic              ex_wme,
    input  logic              ex_mm,
    input  logic              ex_wm,
    input  logic              ex_ni,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_wr_data,
    input  logic              flush,
    output logic              io_we,
    output logic [DATA_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    output logic              wb_valid,
    output logic              wb_wbs,
    output logic              wb_ni,
    output logic [DATA_W-1:0] wb_mem_data,
    output logic [DATA_W-1:0] wb_alu_result
);

    mem_state_e        state, state_nx;
    logic [2:0]        cnt, cnt_nx;
    mem_ctrl_t         ctrl_p0;
    logic [DATA_W-1:0] alu_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              ld_p0;
    logic              done;
    logic              retire;
    logic              accept;
    logic              ram_we;
    logic [DATA_W-1:0] ram_rdata;

    assign ld_p0 = is_load(ctrl_p0);

    // FSM state and remaining-latency counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: a new acceptance always starts ACCESS; flush or retirement
    // empties the stage; a multi-cycle load parks in WAIT counting down.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (accept) begin
            state_nx = ST_ACCESS;
            cnt_nx   = '0;
        end else if (flush || retire) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
        end else if (state == ST_ACCESS) begin
            state_nx = ST_WAIT;
            cnt_nx   = 3'(RD_LAT - 1);
        end else if (state == ST_WAIT) begin
            cnt_nx   = cnt - 3'd1;
        end
    end

    // Outputs: retirement, handshake, RAM write enable and I/O strobe.
    // ex_ready ignores flush; flush instead blocks acceptance directly.
    always_comb begin
        done     = 1'b0;
        io_we    = 1'b0;
        ram_we   = 1'b0;
        io_addr  = '0;
        io_wdata = '0;
        if (state == ST_ACCESS) begin
            done = !ld_p0 || (RD_LAT == 1);
        end else if (state == ST_WAIT) begin
            done = (cnt == 3'd1);
        end
        retire   = done && !flush;
        ex_ready = (state == ST_IDLE) || done;
        accept   = ex_valid && ex_ready && !flush;
        if (state == ST_ACCESS && !flush) begin
            ram_we = is_store(ctrl_p0);
            io_we  = is_io_store(ctrl_p0);
        end
        if (io_we) begin
            io_addr  = alu_p0;
            io_wdata = wdata_p0;
        end
    end

    // ---- MEM register (stage p0) ----
    // Latch the incoming instruction on acceptance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_p0  <= '0;
            alu_p0   <= '0;
            wdata_p0 <= '0;
        end else if (accept) begin
            ctrl_p0  <= '{wbs: ex_wbs, wme: ex_wme, mm: ex_mm, wm: ex_wm, ni: ex_ni};
            alu_p0   <= ex_alu_result;
            wdata_p0 <= ex_wr_data;
        end
    end

    // The read address is taken straight from execute so the RAM pipeline
    // starts on the acceptance edge and finishes as the load retires.
    mem_stage_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (alu_p0[ADDR_W-1:0]),
        .wdata (wdata_p0),
        .raddr (ex_alu_result[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    // ---- WB register (stage p1) ----
    // Capture results on retirement; wb_valid pulses only on that cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid      <= 1'b0;
            wb_wbs        <= 1'b0;
            wb_ni         <= 1'b0;
            wb_mem_data   <= '0;
            wb_alu_result <= '0;
        end else begin
            wb_valid <= retire;
            if (retire) begin
                wb_wbs        <= ctrl_p0.wbs;
                wb_ni         <= ctrl_p0.ni;
                wb_mem_data   <= ld_p0 ? ram_rdata : '0;
                wb_alu_result <= ctrl_p0.wm ? wdata_p0 : alu_p0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: unit 0 runs with RD_LAT=1, unit 1 with RD_LAT=3.
module tb_mem_stage_pipe;

    localparam logic [4:0] C_LOAD  = 5'b10000;  // {wbs,wme,mm,wm,ni}
    localparam logic [4:0] C_STORE = 5'b01000;
    localparam logic [4:0] C_IOST  = 5'b01100;

    logic        clk = 1'b0;
    logic [1:0]  rst, ex_valid, ex_ready, ex_wbs, ex_wme, ex_mm, ex_wm, ex_ni, flush;
    logic [1:0]  io_we, wb_valid, wb_wbs, wb_ni;
    logic [15:0] ex_alu [2];
    logic [15:0] ex_wd [2];
    logic [15:0] io_addr [2];
    logic [15:0] io_wdata [2];
    logic [15:0] wb_mem [2];
    logic [15:0] wb_alu [2];

    int checks = 0;
    int errors = 0;
    int nwb1 = 0;
    int base;
    int st;
    logic [33:0] q0[$];
    logic [33:0] q1[$];

    always #5 clk = ~clk;

    mem_stage_pipe #(.DATA_W(16), .ADDR_W(8), .RD_LAT(1)) u0 (
        .clk(clk), .rst(rst[0]), .ex_valid(ex_valid[0]), .ex_ready(ex_ready[0]),
        .ex_wbs(ex_wbs[0]), .ex_wme(ex_wme[0]), .ex_mm(ex_mm[0]), .ex_wm(ex_wm[0]), .ex_ni(ex_ni[0]),
        .ex_alu_result(ex_alu[0]), .ex_wr_data(ex_wd[0]), .flush(flush[0]),
        .io_we(io_we[0]), .io_addr(io_addr[0]), .io_wdata(io_wdata[0]),
        .wb_valid(wb_valid[0]), .wb_wbs(wb_wbs[0]), .wb_ni(wb_ni[0]),
        .wb_mem_data(wb_mem[0]), .wb_alu_result(wb_alu[0]));

    mem_stage_pipe #(.DATA_W(16), .ADDR_W(8), .RD_LAT(3)) u1 (
        .clk(clk), .rst(rst[1]), .ex_valid(ex_valid[1]), .ex_ready(ex_ready[1]),
        .ex_wbs(ex_wbs[1]), .ex_wme(ex_wme[1]), .ex_mm(ex_mm[1]), .ex_wm(ex_wm[1]), .ex_ni(ex_ni[1]),
        .ex_alu_result(ex_alu[1]), .ex_wr_data(ex_wd[1]), .flush(flush[1]),
        .io_we(io_we[1]), .io_addr(io_addr[1]), .io_wdata(io_wdata[1]),
        .wb_valid(wb_valid[1]), .wb_wbs(wb_wbs[1]), .wb_ni(wb_ni[1]),
        .wb_mem_data(wb_mem[1]), .wb_alu_result(wb_alu[1]));

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one instruction from a negedge; wait for ex_ready, return at the
    // negedge after acceptance with ex_valid still high. Expected WB entry is
    // {wbs, ni, mem_data, alu_result}.
    task automatic issue(input int u, input logic [4:0] c, input logic [15:0] alu,
                         input logic [15:0] wd, input bit push, input logic [15:0] exp_mem,
                         input logic [15:0] exp_alu, output int stalls);
        ex_valid[u] = 1'b1;
        {ex_wbs[u], ex_wme[u], ex_mm[u], ex_wm[u], ex_ni[u]} = c;
        ex_alu[u] = alu;
        ex_wd[u]  = wd;
        stalls = 0;
        while (ex_ready[u] !== 1'b1 && stalls < 16) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 16) chk("issue_timeout", 34'(ex_ready[u]), 34'd1);
        if (push) begin
            if (u == 0) q0.push_back({c[4], c[0], exp_mem, exp_alu});
            else        q1.push_back({c[4], c[0], exp_mem, exp_alu});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int u, input int n);
        ex_valid[u] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Scoreboard: every wb_valid pulse must match the oldest expected entry
    always @(negedge clk) begin
        if (wb_valid[0] === 1'b1) begin
            if (q0.size() == 0) chk("wb0_unexpected", 34'd1, 34'd0);
            else chk("wb0_data", {wb_wbs[0], wb_ni[0], wb_mem[0], wb_alu[0]}, q0.pop_front());
        end
        if (wb_valid[1] === 1'b1) begin
            nwb1++;
            if (q1.size() == 0) chk("wb1_unexpected", 34'd1, 34'd0);
            else chk("wb1_data", {wb_wbs[1], wb_ni[1], wb_mem[1], wb_alu[1]}, q1.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 2'b11; ex_valid = '0; ex_wbs = '0; ex_wme = '0; ex_mm = '0; ex_wm = '0; ex_ni = '0;
        flush = '0;
        for (int u = 0; u < 2; u++) begin ex_alu[u] = '0; ex_wd[u] = '0; end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", 34'(ex_ready[u]), 34'd1);
            chk("rst_wbv", 34'(wb_valid[u]), 34'd0);
            chk("rst_iowe", 34'(io_we[u]), 34'd0);
            chk("rst_wbdata", {wb_wbs[u], wb_ni[u], wb_mem[u], wb_alu[u]}, 34'd0);
            chk("rst_ioaddr", 34'(io_addr[u]), 34'd0);
        end
        rst = 2'b00;
        @(negedge clk);

        // Unit 0, RD_LAT=1: store then immediate load of the same address
        issue(0, C_STORE, 16'h0002, 16'h00FF, 1, 16'h0000, 16'h0002, st);
        issue(0, C_LOAD, 16'h0002, 16'h0000, 1, 16'h00FF, 16'h0002, st);
        chk("ld1_stalls", 34'(st), 34'd0);
        chk("ld1_ready", 34'(ex_ready[0]), 34'd1);
        idle(0, 1);
        chk("ld1_wbv", 34'(wb_valid[0]), 34'd1);
        chk("ld1_data", 34'(wb_mem[0]), 34'h00FF);

        // Address wrap: 0x0100 lands on word 0; then an I/O store must not touch RAM
        issue(0, C_STORE, 16'h0100, 16'h1234, 1, 16'h0000, 16'h0100, st);
        issue(0, C_IOST, 16'hFF00, 16'h00FF, 1, 16'h0000, 16'hFF00, st);
        chk("io_we", 34'(io_we[0]), 34'd1);
        chk("io_addr", 34'(io_addr[0]), 34'hFF00);
        chk("io_wdata", 34'(io_wdata[0]), 34'h00FF);
        idle(0, 1);
        chk("io_we_off", 34'(io_we[0]), 34'd0);
        issue(0, C_LOAD, 16'h0000, 16'h0000, 1, 16'h1234, 16'h0000, st);
        idle(0, 2);

        // Pass-through result mux
        issue(0, 5'b00011, 16'hAAAA, 16'h5555, 1, 16'h0000, 16'h5555, st);
        issue(0, 5'b00000, 16'hAAAA, 16'h5555, 1, 16'h0000, 16'hAAAA, st);
        idle(0, 2);

        // Flushed store to 0x05 leaves the earlier (wrapped) value in place
        issue(0, C_STORE, 16'h0305, 16'h0BEE, 1, 16'h0000, 16'h0305, st);
        issue(0, C_STORE, 16'h0005, 16'hDEAD, 0, 16'h0000, 16'h0000, st);
        ex_valid[0] = 1'b0;
        flush[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b0;
        chk("flush_st_wbv", 34'(wb_valid[0]), 34'd0);
        issue(0, C_LOAD, 16'h0005, 16'h0000, 1, 16'h0BEE, 16'h0005, st);
        idle(0, 2);

        // Unit 1, RD_LAT=3: load stalls the following instruction two cycles
        base = nwb1;
        issue(1, C_STORE, 16'h0002, 16'h00FF, 1, 16'h0000, 16'h0002, st);
        issue(1, C_LOAD, 16'h0002, 16'h0000, 1, 16'h00FF, 16'h0002, st);
        chk("ld3_own_stalls", 34'(st), 34'd0);
        issue(1, 5'b00001, 16'h0011, 16'h0022, 1, 16'h0000, 16'h0011, st);
        chk("ld3_stalls", 34'(st), 34'd2);
        idle(1, 4);
        chk("ld3_pulses", 34'(nwb1 - base), 34'd3);

        // Flush while the load sits in WAIT
        issue(1, C_LOAD, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0000, st);
        ex_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("wait_ready", 34'(ex_ready[1]), 34'd0);
        flush[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[1] = 1'b0;
        chk("flush_wait_ready", 34'(ex_ready[1]), 34'd1);
        chk("flush_wait_wbv", 34'(wb_valid[1]), 34'd0);
        idle(1, 4);

        // Flush coinciding with ex_valid: the load must not be accepted
        ex_valid[1] = 1'b1;
        {ex_wbs[1], ex_wme[1], ex_mm[1], ex_wm[1], ex_ni[1]} = C_LOAD;
        ex_alu[1] = 16'h0002;
        flush[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ex_valid[1] = 1'b0;
        flush[1] = 1'b0;
        chk("flush_wins", 34'(ex_ready[1]), 34'd1);
        idle(1, 4);

        // Reset in the middle of a load
        issue(1, 5'b10101, 16'h7777, 16'h0001, 1, 16'h0000, 16'h7777, st);
        issue(1, C_LOAD, 16'h0002, 16'h0000, 0, 16'h0000, 16'h0000, st);
        ex_valid[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_alu", 34'(wb_alu[1]), 34'h7777);
        rst[1] = 1'b1;
        #1;
        chk("midrst_ready", 34'(ex_ready[1]), 34'd1);
        chk("midrst_wbv", 34'(wb_valid[1]), 34'd0);
        chk("midrst_wb", {wb_wbs[1], wb_ni[1], wb_mem[1], wb_alu[1]}, 34'd0);
        chk("midrst_iowe", 34'(io_we[1]), 34'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        idle(1, 1);
        issue(1, C_LOAD, 16'h0002, 16'h0000, 1, 16'h00FF, 16'h0002, st);
        idle(1, 5);

        chk("q0_drained", 34'(q0.size()), 34'd0);
        chk("q1_drained", 34'(q1.size()), 34'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
